// File: rtl/ysyx_2022040010_wb_pkg.sv
// Shared types and sizing constants for the write-back arbiter.
// The entry layout is sized by WB_DATA_W / WB_ADDR_W. The arbiter's
// DATA_W / ADDR_W parameters default to these values.
package ysyx_2022040010_wb_pkg;

   localparam int WB_DATA_W       = 64;
   localparam int WB_ADDR_W       = 5;
   localparam int WB_FIFO_DEPTH   = 2;
   localparam int WB_STARVE_LIMIT = 8;
   localparam int WB_STALL_W      = 6;

   typedef struct packed {
      logic                 valid;
      logic [WB_ADDR_W-1:0] waddr;
      logic [WB_DATA_W-1:0] wdata;
   } wb_entry_t;

endpackage

// File: rtl/ysyx_2022040010_wb_fifo.sv
// Two-entry queue of long-latency results waiting for a register file slot.
// An occupied entry can be invalidated in place by a younger write to the
// same register. It then stays queued until the arbiter drops it.
// With YSYX_WB_STATS_EN defined, the queue also reports how many entries
// one invalidate hit.
module ysyx_2022040010_wb_fifo
   import ysyx_2022040010_wb_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [WB_ADDR_W-1:0] push_waddr,
   input  logic [WB_DATA_W-1:0] push_wdata,
   input  logic                 pop,
   input  logic                 inv,
   input  logic [WB_ADDR_W-1:0] inv_addr,
   output logic                 empty,
   output logic                 full,
   output logic                 head_valid,
   output logic                 head_hit,
   output logic [WB_ADDR_W-1:0] head_waddr,
   output logic [WB_DATA_W-1:0] head_wdata
`ifdef YSYX_WB_STATS_EN
   ,
   output logic [1:0]           inv_cnt
`endif
);

   wb_entry_t                mem [WB_FIFO_DEPTH];
   wb_entry_t                head;
   logic                     rd_ptr;
   logic                     wr_ptr;
   logic [1:0]               cnt;
   logic [WB_FIFO_DEPTH-1:0] occ;
   logic [WB_FIFO_DEPTH-1:0] hit;
   logic                     do_push;
   logic                     do_pop;

   assign empty      = (cnt == 2'd0);
   assign full       = (cnt == 2'd2);
   assign head       = mem[rd_ptr];
   assign head_valid = !empty && head.valid;
   assign head_waddr = head.waddr;
   assign head_wdata = head.wdata;
   assign head_hit   = hit[rd_ptr];
   assign do_pop     = pop && !empty;
   // A full queue still accepts a push when the head leaves in the same cycle.
   assign do_push    = push && (!full || do_pop);

`ifdef YSYX_WB_STATS_EN
   assign inv_cnt = {1'b0, hit[0]} + {1'b0, hit[1]};
`endif

   // Mark live slots and the live, still-valid ones an invalidate would hit.
   always_comb begin
      for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
         occ[i] = full || (!empty && (rd_ptr == 1'(i)));
         hit[i] = inv && occ[i] && mem[i].valid && (mem[i].waddr == inv_addr);
      end
   end

   // Apply invalidates, push, pop and the occupancy update. Pointers wrap mod 2.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
            if (hit[i]) begin
               mem[i].valid <= 1'b0;
            end
         end
         if (do_push) begin
            mem[wr_ptr] <= '{valid: 1'b1, waddr: push_waddr, wdata: push_wdata};
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

endmodule

// File: rtl/ysyx_2022040010_wb_arb.sv
// Write-back arbiter. It merges MEM-stage results with long-latency unit
// results onto the single register file write port.
// MEM writes win. LU results bypass when nothing is queued, and otherwise
// wait in a squashable 2-entry queue. A head that waits too long raises
// stallreq so that it can drain.
// Optional build macro YSYX_WB_STATS_EN adds the cnt_squash and cnt_starve
// counters.
module ysyx_2022040010_wb_arb
   import ysyx_2022040010_wb_pkg::*;
#(
   parameter int DATA_W       = WB_DATA_W,
   parameter int ADDR_W       = WB_ADDR_W,
   parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WB_STALL_W-1:0] stall,
   input  logic                  mem_we,
   input  logic [ADDR_W-1:0]     mem_waddr,
   input  logic [DATA_W-1:0]     mem_wdata,
   input  logic                  lu_valid,
   output logic                  lu_ready,
   input  logic [ADDR_W-1:0]     lu_waddr,
   input  logic [DATA_W-1:0]     lu_wdata,
   output logic                  we,
   output logic [ADDR_W-1:0]     waddr,
   output logic [DATA_W-1:0]     wdata,
   output logic                  stallreq
`ifdef YSYX_WB_STATS_EN
   ,
   output logic [31:0]           cnt_squash,
   output logic [31:0]           cnt_starve
`endif
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic              run;
   logic              mem_hit;
   logic              lu_xfer;
   logic              sel_mem;
   logic              sel_pop;
   logic              sel_byp;
   logic              lu_squash;
   logic              fifo_push;
   logic              fifo_pop;
   logic              empty;
   logic              full;
   logic              head_valid;
   logic              head_hit;
   logic [ADDR_W-1:0] head_waddr;
   logic [DATA_W-1:0] head_wdata;
   logic [SW-1:0]     starve_cnt;
   logic              unused_stall;

   // Only bit 3 of the stall bus concerns this stage.
   assign unused_stall = ^{stall[5:4], stall[2:0]};

   assign run      = !stall[3];
   assign mem_hit  = mem_we && (mem_waddr != '0);
   assign lu_ready = !full && !rst;
   assign lu_xfer  = lu_valid && lu_ready;

   // Priority: MEM capture, then a valid queue head, then the LU bypass.
   assign sel_mem   = run && mem_hit;
   assign sel_pop   = run && !mem_hit && head_valid;
   assign sel_byp   = run && !mem_hit && empty && lu_valid;
   // The LU result is older than a MEM write to the same register, so it dies.
   assign lu_squash = sel_mem && lu_xfer && (lu_waddr == mem_waddr);
   assign fifo_push = lu_xfer && !sel_byp && !lu_squash && (lu_waddr != '0);
   // An invalidated head leaves on any running cycle without using the port.
   assign fifo_pop  = run && !empty && (sel_pop || !head_valid);

`ifdef YSYX_WB_STATS_EN
   logic [1:0]  inv_cnt;
   logic [1:0]  sq_cnt;
   logic [32:0] sq_sum;
`endif

   ysyx_2022040010_wb_fifo u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (fifo_push),
      .push_waddr (lu_waddr),
      .push_wdata (lu_wdata),
      .pop        (fifo_pop),
      .inv        (sel_mem),
      .inv_addr   (mem_waddr),
      .empty      (empty),
      .full       (full),
      .head_valid (head_valid),
      .head_hit   (head_hit),
      .head_waddr (head_waddr),
      .head_wdata (head_wdata)
`ifdef YSYX_WB_STATS_EN
      ,
      .inv_cnt    (inv_cnt)
`endif
   );

   // Register the selected write. While stalled, everything holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we    <= 1'b0;
         waddr <= '0;
         wdata <= '0;
      end else if (run) begin
         if (sel_mem) begin
            we    <= 1'b1;
            waddr <= mem_waddr;
            wdata <= mem_wdata;
         end else if (sel_pop) begin
            we    <= 1'b1;
            waddr <= head_waddr;
            wdata <= head_wdata;
         end else if (sel_byp) begin
            we    <= (lu_waddr != '0);
            waddr <= lu_waddr;
            wdata <= lu_wdata;
         end else begin
            we <= 1'b0;
         end
      end
   end

   // Count the running cycles that a valid head is passed over.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (run) begin
         if (empty || fifo_pop || head_hit) begin
            starve_cnt <= '0;
         end else if (head_valid && (starve_cnt != SW'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + SW'(1);
         end
      end
   end

   assign stallreq = (starve_cnt >= SW'(STARVE_LIMIT));

`ifdef YSYX_WB_STATS_EN
   assign sq_cnt = inv_cnt + {1'b0, lu_squash};
   assign sq_sum = {1'b0, cnt_squash} + {31'b0, sq_cnt};

   // Saturating event counters for squashes and starvation cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_squash <= '0;
         cnt_starve <= '0;
      end else begin
         cnt_squash <= sq_sum[32] ? '1 : sq_sum[31:0];
         if (stallreq && (cnt_starve != '1)) begin
            cnt_starve <= cnt_starve + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ysyx_2022040010_wb_arb.sv
// Bench for ysyx_2022040010_wb_arb: directed vector table, an asynchronous
// reset sequence, then randomized traffic compared to a queue-based model.
module tb_ysyx_2022040010_wb_arb;

   localparam int LIMIT = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        mem_we;
   logic [4:0]  mem_waddr;
   logic [63:0] mem_wdata;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_waddr;
   logic [63:0] lu_wdata;
   logic        we;
   logic [4:0]  waddr;
   logic [63:0] wdata;
   logic        stallreq;
`ifdef YSYX_WB_STATS_EN
   logic [31:0] cnt_squash;
   logic [31:0] cnt_starve;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ysyx_2022040010_wb_arb dut (
      .clk       (clk),
      .rst       (rst),
      .stall     (stall),
      .mem_we    (mem_we),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata),
      .lu_valid  (lu_valid),
      .lu_ready  (lu_ready),
      .lu_waddr  (lu_waddr),
      .lu_wdata  (lu_wdata),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .stallreq  (stallreq)
`ifdef YSYX_WB_STATS_EN
      ,
      .cnt_squash(cnt_squash),
      .cnt_starve(cnt_starve)
`endif
   );

   // Reference model: queue of pending LU results plus the visible write.
   typedef struct {
      bit          v;
      logic [4:0]  a;
      logic [63:0] d;
   } ent_t;

   ent_t        mq[$];
   bit          m_we;
   logic [4:0]  m_wa;
   logic [63:0] m_wd;
   int          m_wait;
   int unsigned m_sq;
   int unsigned m_starve;

   typedef struct {
      bit          st;
      bit          mwe;
      logic [4:0]  ma;
      logic [63:0] md;
      bit          lv;
      logic [4:0]  la;
      logic [63:0] ld;
      bit          ewe;
      logic [4:0]  ea;
      logic [63:0] ed;
      bit          erdy;
      bit          esr;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add(input bit st, input bit mwe, input logic [4:0] ma, input logic [63:0] md,
                      input bit lv, input logic [4:0] la, input logic [63:0] ld,
                      input bit ewe, input logic [4:0] ea, input logic [63:0] ed,
                      input bit erdy, input bit esr);
      vec_t v;
      v.st = st; v.mwe = mwe; v.ma = ma; v.md = md;
      v.lv = lv; v.la = la; v.ld = ld;
      v.ewe = ewe; v.ea = ea; v.ed = ed; v.erdy = erdy; v.esr = esr;
      tbl.push_back(v);
   endtask

   task automatic model_reset();
      mq.delete();
      m_we = 1'b0; m_wa = '0; m_wd = '0;
      m_wait = 0; m_sq = 0; m_starve = 0;
   endtask

   task automatic model_push();
      ent_t n;
      n.v = 1'b1; n.a = lu_waddr; n.d = lu_wdata;
      mq.push_back(n);
   endtask

   // Advance the model by one rising edge using the inputs driven right now.
   task automatic model_edge();
      bit   run, hit, xfer, empty_pre, head_v, popped, head_sq;
      ent_t e;
      run       = !stall[3];
      hit       = mem_we && (mem_waddr != 5'd0);
      xfer      = lu_valid && (mq.size() < 2);
      empty_pre = (mq.size() == 0);
      head_v    = !empty_pre && mq[0].v;
      popped    = 1'b0;
      head_sq   = 1'b0;
      if (m_wait >= LIMIT) m_starve++;
      if (!run) begin
         if (xfer && lu_waddr != 5'd0) model_push();
      end else if (hit) begin
         m_we = 1'b1; m_wa = mem_waddr; m_wd = mem_wdata;
         for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].v && mq[i].a == mem_waddr) begin
               e = mq[i]; e.v = 1'b0; mq[i] = e;
               m_sq++;
               if (i == 0) head_sq = 1'b1;
            end
         end
         if (!empty_pre && !head_v) begin
            e = mq.pop_front(); popped = 1'b1;
         end
         if (xfer && lu_waddr == mem_waddr) m_sq++;
         else if (xfer && lu_waddr != 5'd0) model_push();
      end else if (head_v) begin
         e = mq.pop_front(); popped = 1'b1;
         m_we = 1'b1; m_wa = e.a; m_wd = e.d;
         if (xfer && lu_waddr != 5'd0) model_push();
      end else if (empty_pre && lu_valid) begin
         m_we = (lu_waddr != 5'd0); m_wa = lu_waddr; m_wd = lu_wdata;
      end else begin
         m_we = 1'b0;
         if (!empty_pre) begin
            e = mq.pop_front(); popped = 1'b1;
         end
         if (xfer && lu_waddr != 5'd0) model_push();
      end
      if (run) begin
         if (empty_pre || popped || head_sq) m_wait = 0;
         else if (head_v) m_wait = (m_wait < LIMIT) ? m_wait + 1 : LIMIT;
      end
   endtask

   task automatic drive_idle();
      stall = '0; mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
      lu_valid = 1'b0; lu_waddr = '0; lu_wdata = '0;
   endtask

   task automatic apply(input vec_t v);
      stall     = {2'b00, v.st, 3'b000};
      mem_we    = v.mwe; mem_waddr = v.ma; mem_wdata = v.md;
      lu_valid  = v.lv;  lu_waddr  = v.la; lu_wdata  = v.ld;
   endtask

   initial begin
      rst = 1'b1;
      drive_idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_we", we, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_lu_ready", lu_ready, 0);
      chk("rst_stallreq", stallreq, 0);
      rst = 1'b0;
      #1;
      chk("rel_lu_ready", lu_ready, 1);

      // st mwe ma md | lv la ld | ewe ea ed | rdy sr
      add(0, 1, 5, 64'h1234, 0, 0, 0,        1, 5, 64'h1234, 1, 0); // MEM x5
      add(0, 1, 0, 64'h5555, 0, 0, 0,        0, 0, 0,        1, 0); // MEM x0 dropped
      add(0, 0, 0, 0,        1, 7, 64'hAA,   1, 7, 64'hAA,   1, 0); // LU bypass
      add(0, 1, 3, 64'h1,    1, 4, 64'h2,    1, 3, 64'h1,    1, 0); // collision
      add(0, 0, 0, 0,        0, 0, 0,        1, 4, 64'h2,    1, 0); // queued x4
      add(0, 0, 0, 0,        0, 0, 0,        0, 0, 0,        1, 0);
      add(0, 1, 1, 64'h11,   1, 9, 64'h1,    1, 1, 64'h11,   1, 0); // queue x9=1
      add(0, 1, 9, 64'h2,    0, 0, 0,        1, 9, 64'h2,    1, 0); // squash x9
      add(0, 0, 0, 0,        0, 0, 0,        0, 0, 0,        1, 0); // dead head dropped
      add(0, 0, 0, 0,        0, 0, 0,        0, 0, 0,        1, 0);
      add(0, 1, 1, 64'h100,  1, 10, 64'hA0,  1, 1, 64'h100,  1, 0); // fill
      add(0, 1, 2, 64'h101,  1, 11, 64'hB0,  1, 2, 64'h101,  0, 0); // full
      for (int k = 0; k < 6; k++)
         add(0, 1, 1, 64'h200 + 64'(k), 0, 0, 0, 1, 1, 64'h200 + 64'(k), 0, 0);
      add(0, 1, 1, 64'h206,  0, 0, 0,        1, 1, 64'h206,  0, 1); // 8 waits
      add(0, 0, 0, 0,        0, 0, 0,        1, 10, 64'hA0,  1, 0); // head drains
      add(0, 0, 0, 0,        0, 0, 0,        1, 11, 64'hB0,  1, 0);
      add(0, 1, 1, 64'h300,  1, 12, 64'hC0,  1, 1, 64'h300,  1, 0); // queue x12
      for (int k = 0; k < 7; k++)
         add(0, 1, 1, 64'h310 + 64'(k), 0, 0, 0, 1, 1, 64'h310 + 64'(k), 1, 0);
      for (int k = 0; k < 3; k++)
         add(1, 1, 13, 64'h400, 0, 0, 0,     1, 1, 64'h316,  1, 0); // stalled: hold
      add(0, 1, 13, 64'h400, 0, 0, 0,        1, 13, 64'h400, 1, 1); // MEM first
      add(0, 0, 0, 0,        0, 0, 0,        1, 12, 64'hC0,  1, 0); // then head

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i]);
         model_edge();
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_we", i), we, tbl[i].ewe);
         if (tbl[i].ewe) begin
            chk($sformatf("v%0d_waddr", i), waddr, tbl[i].ea);
            chk($sformatf("v%0d_wdata", i), wdata, tbl[i].ed);
         end
         chk($sformatf("v%0d_lu_ready", i), lu_ready, tbl[i].erdy);
         chk($sformatf("v%0d_stallreq", i), stallreq, tbl[i].esr);
`ifdef YSYX_WB_STATS_EN
         if (i == 9) chk("v9_cnt_squash", cnt_squash, 1);
`endif
      end

      // Reset asserted between edges with two entries queued and we=1.
      stall = '0; mem_we = 1'b1; mem_waddr = 5'd1; mem_wdata = 64'h7;
      lu_valid = 1'b1; lu_waddr = 5'd20; lu_wdata = 64'h1;
      model_edge();
      @(posedge clk);
      #1;
      mem_waddr = 5'd2; mem_wdata = 64'h8; lu_waddr = 5'd21; lu_wdata = 64'h2;
      model_edge();
      @(posedge clk);
      #1;
      chk("prerst_lu_ready", lu_ready, 0);
      chk("prerst_we", we, 1);
      drive_idle();
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst_we", we, 0);
      chk("async_rst_waddr", waddr, 0);
      chk("async_rst_wdata", wdata, 0);
      chk("async_rst_lu_ready", lu_ready, 0);
      chk("async_rst_stallreq", stallreq, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         model_edge();
         @(posedge clk);
         #1;
         chk($sformatf("postrst%0d_we", k), we, 0);
         chk($sformatf("postrst%0d_lu_ready", k), lu_ready, 1);
      end

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         stall = ($urandom_range(0, 4) == 0) ? 6'b001000 : (6'($urandom) & 6'b110111);
         if (!(lu_valid && mq.size() >= 2)) begin
            lu_valid = 1'($urandom_range(0, 1));
            lu_waddr = 5'($urandom_range(0, 7));
            lu_wdata = {$urandom, $urandom};
         end
         mem_we    = (m_wait >= LIMIT) ? 1'b0 : ($urandom_range(0, 2) != 0);
         mem_waddr = 5'($urandom_range(0, 7));
         mem_wdata = {$urandom, $urandom};
         model_edge();
         @(posedge clk);
         #1;
         chk($sformatf("r%0d_we", c), we, m_we);
         if (m_we) begin
            chk($sformatf("r%0d_waddr", c), waddr, m_wa);
            chk($sformatf("r%0d_wdata", c), wdata, m_wd);
         end
         chk($sformatf("r%0d_lu_ready", c), lu_ready, mq.size() < 2);
         chk($sformatf("r%0d_stallreq", c), stallreq, m_wait >= LIMIT);
`ifdef YSYX_WB_STATS_EN
         chk($sformatf("r%0d_cnt_squash", c), cnt_squash, m_sq);
         chk($sformatf("r%0d_cnt_starve", c), cnt_starve, m_starve);
`endif
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
